// File: rtl/param_alu_acc_if.sv
// Operand/command and result/handshake bundle for param_alu_acc.
// master drives the request, slave returns the accumulator and status.
interface param_alu_acc_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0]   A;
    logic [2:0]         Op;
    logic               Start;
    logic [2*WIDTH-1:0] Acc;
    logic               Carry;
    logic               Busy;
    logic               Done;

    modport master (
        output A, Op, Start,
        input  Acc, Carry, Busy, Done
    );

    modport slave (
        input  A, Op, Start,
        output Acc, Carry, Busy, Done
    );
endinterface

// File: rtl/param_alu_acc.sv
// Accumulator ALU with start/busy/done handshake and registered carry.
// Define PARAM_ALU_MUL_EN to build the multi-cycle shift-add multiplier.
module param_alu_acc #(
    parameter int WIDTH = 4
) (
    input  logic           Clock,
    input  logic           Reset_b,
    param_alu_acc_if.slave bus
);
    localparam int AW = 2 * WIDTH;

    localparam logic [2:0] OP_ADD    = 3'b000;
    localparam logic [2:0] OP_ACCADD = 3'b001;
    localparam logic [2:0] OP_NLOGIC = 3'b010;
    localparam logic [2:0] OP_ANYSET = 3'b011;
    localparam logic [2:0] OP_SWAP   = 3'b101;
    localparam logic [2:0] OP_XLOGIC = 3'b110;

    logic [AW-1:0]    acc_q;
    logic             carry_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH:0]   add_sum;
    logic [AW:0]      acc_sum;
    logic [AW-1:0]    acc_nxt;
    logic             carry_nxt;

    assign opa     = bus.A;
    assign opb     = acc_q[AW-1:WIDTH];
    assign add_sum = {1'b0, opa} + {1'b0, opb};
    assign acc_sum = {1'b0, acc_q} + {{(WIDTH+1){1'b0}}, opa};

    // Single-cycle result; MUL and HOLD fall through to "unchanged".
    always_comb begin
        acc_nxt   = acc_q;
        carry_nxt = carry_q;
        case (bus.Op)
            OP_ADD: begin
                acc_nxt   = {{(WIDTH-1){1'b0}}, add_sum};
                carry_nxt = add_sum[WIDTH];
            end
            OP_ACCADD: begin
                acc_nxt   = acc_sum[AW-1:0];
                carry_nxt = acc_sum[AW];
            end
            OP_NLOGIC: acc_nxt = {~(opa | opb), ~(opa & opb)};
            OP_ANYSET: acc_nxt = (|opa || |opb) ? {2'b11, {(AW-2){1'b0}}} : '0;
            OP_SWAP:   acc_nxt = {opb, ~opa};
            OP_XLOGIC: acc_nxt = {opa ^ opb, opa ~^ opb};
            default:   ;
        endcase
    end

`ifdef PARAM_ALU_MUL_EN
    localparam logic [2:0] OP_MUL = 3'b100;
    localparam int         CW     = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, MULT} state_t;

    state_t           state;
    logic [WIDTH-1:0] mul_a;
    logic [WIDTH-1:0] mul_b;
    logic [AW-1:0]    prod;
    logic [AW-1:0]    prod_nxt;
    logic [CW-1:0]    cnt;

    // Partial product stays internal; Acc only sees the final sum.
    assign prod_nxt = prod + (mul_b[cnt] ? ({{WIDTH{1'b0}}, mul_a} << cnt) : '0);

    always_ff @(posedge Clock) begin
        if (!Reset_b) begin
            state   <= IDLE;
            acc_q   <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            mul_a   <= '0;
            mul_b   <= '0;
            prod    <= '0;
            cnt     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.Start) begin
                        if (bus.Op == OP_MUL) begin
                            mul_a  <= opa;
                            mul_b  <= opb;
                            prod   <= '0;
                            cnt    <= '0;
                            busy_q <= 1'b1;
                            state  <= MULT;
                        end else begin
                            acc_q   <= acc_nxt;
                            carry_q <= carry_nxt;
                            done_q  <= 1'b1;
                        end
                    end
                end
                MULT: begin
                    prod <= prod_nxt;
                    if (cnt == CNT_LAST) begin
                        acc_q  <= prod_nxt;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
            endcase
        end
    end
`else
    assign busy_q = 1'b0;

    always_ff @(posedge Clock) begin
        if (!Reset_b) begin
            acc_q   <= '0;
            carry_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.Start) begin
                acc_q   <= acc_nxt;
                carry_q <= carry_nxt;
                done_q  <= 1'b1;
            end
        end
    end
`endif

    assign bus.Acc   = acc_q;
    assign bus.Carry = carry_q;
    assign bus.Busy  = busy_q;
    assign bus.Done  = done_q;
endmodule

// File: tb/tb_param_alu_acc.sv
// Scoreboard bench for param_alu_acc: directed cases plus random ops
// against an arithmetic reference model.
module tb_param_alu_acc;
    localparam int W  = 4;
    localparam int AW = 2 * W;
    localparam int unsigned M    = 1 << W;
    localparam int unsigned MASK = M - 1;

    typedef struct {
        int unsigned acc;
        logic        carry;
        int unsigned due;
    } exp_t;

    logic Clock;
    logic Reset_b;

    param_alu_acc_if #(.WIDTH(W)) bus ();

    param_alu_acc #(.WIDTH(W)) dut (
        .Clock   (Clock),
        .Reset_b (Reset_b),
        .bus     (bus)
    );

    int unsigned n_pass;
    int unsigned n_total;
    int unsigned cyc;
    int unsigned m_acc;
    logic        m_carry;
    int unsigned m_busy;
    int unsigned m_prod;
    exp_t        q[$];

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                      nm, got, exp, cyc);
    endtask

    // Reference model: advanced once per rising edge from the driven inputs.
    task automatic model_step();
        int unsigned a;
        int unsigned b;
        int unsigned s;
        cyc++;
        if (!Reset_b) begin
            m_acc   = 0;
            m_carry = 1'b0;
            m_busy  = 0;
            q.delete();
            return;
        end
        if (m_busy != 0) begin
            m_busy--;
            if (m_busy == 0) m_acc = m_prod;
            return;
        end
        if (!bus.Start) return;
        a = 32'(bus.A);
        b = m_acc / M;
        case (bus.Op)
            3'd0: begin
                s = a + b;
                m_acc = s;
                m_carry = (s >= M);
            end
            3'd1: begin
                s = m_acc + a;
                m_carry = (s >= M * M);
                m_acc = s % (M * M);
            end
            3'd2: m_acc = ((~(a | b)) & MASK) * M + ((~(a & b)) & MASK);
            3'd3: m_acc = (a != 0 || b != 0) ? (32'd3 << (AW - 2)) : 0;
            3'd4: begin
`ifdef PARAM_ALU_MUL_EN
                m_prod = a * b;
                m_busy = W;
                q.push_back('{acc: a * b, carry: m_carry, due: cyc + W});
                return;
`endif
            end
            3'd5: m_acc = b * M + ((~a) & MASK);
            3'd6: m_acc = ((a ^ b) & MASK) * M + ((~(a ^ b)) & MASK);
            default: ;
        endcase
        q.push_back('{acc: m_acc, carry: m_carry, due: cyc});
    endtask

    task automatic tick(input logic rb, input logic st,
                        input logic [2:0] op, input int unsigned a);
        #2;
        Reset_b   = rb;
        bus.Start = st;
        bus.Op    = op;
        bus.A     = W'(a);
        @(posedge Clock);
        model_step();
    endtask

    task automatic idle();
        tick(1'b1, 1'b0, 3'd0, 0);
    endtask

    // Load Acc = {hi, lo} with XLOGIC then SWAP, using the model's B.
    task automatic set_acc(input int unsigned hi, input int unsigned lo);
        tick(1'b1, 1'b1, 3'd6, (hi ^ (m_acc / M)) & MASK);
        tick(1'b1, 1'b1, 3'd5, (~lo) & MASK);
    endtask

    // Monitor: pops the scoreboard on Done, tracks Busy and Acc each cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge Clock);
            chk("busy", 32'(bus.Busy), 32'(m_busy != 0));
            chk("acc", 32'(bus.Acc), m_acc);
            if (bus.Done) begin
                if (q.size() == 0) begin
                    chk("done_unexpected", 32'(bus.Done), 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("sb_acc", 32'(bus.Acc), e.acc);
                    chk("sb_carry", 32'(bus.Carry), 32'(e.carry));
                    chk("sb_latency", cyc, e.due);
                end
            end else if (q.size() != 0 && q[0].due < cyc) begin
                chk("done_missing", 32'(bus.Done), 32'd1);
                void'(q.pop_front());
            end
        end
    end

    initial begin
        n_pass    = 0;
        n_total   = 0;
        cyc       = 0;
        m_acc     = 0;
        m_carry   = 1'b0;
        m_busy    = 0;
        m_prod    = 0;
        Reset_b   = 1'b0;
        bus.Start = 1'b0;
        bus.Op    = 3'd0;
        bus.A     = '0;

        tick(1'b0, 1'b1, 3'd1, 5);
        tick(1'b0, 1'b1, 3'd1, 5);
        #1;
        chk("rst_acc", 32'(bus.Acc), 32'h00);
        chk("rst_carry", 32'(bus.Carry), 32'd0);
        chk("rst_busy", 32'(bus.Busy), 32'd0);
        chk("rst_done", 32'(bus.Done), 32'd0);
        idle();

        set_acc(7, 0);
        tick(1'b1, 1'b1, 3'd0, 9);
        #1;
        chk("add_acc", 32'(bus.Acc), 32'h10);
        chk("add_carry", 32'(bus.Carry), 32'd1);
        chk("add_done", 32'(bus.Done), 32'd1);
        idle();
        #1;
        chk("add_done_clr", 32'(bus.Done), 32'd0);

        set_acc(4'hF, 4'hE);
        tick(1'b1, 1'b1, 3'd1, 3);
        #1;
        chk("accadd_acc", 32'(bus.Acc), 32'h01);
        chk("accadd_carry", 32'(bus.Carry), 32'd1);
        tick(1'b1, 1'b1, 3'd5, 3);
        #1;
        chk("swap_acc", 32'(bus.Acc), 32'h0C);
        chk("swap_carry", 32'(bus.Carry), 32'd1);
        idle();

`ifdef PARAM_ALU_MUL_EN
        set_acc(4'hD, 0);
        tick(1'b1, 1'b1, 3'd4, 4'hF);
        #1;
        chk("mul_busy0", 32'(bus.Busy), 32'd1);
        for (int i = 1; i < W; i++) begin
            tick(1'b1, 1'b1, 3'd0, $urandom_range(0, MASK));
            #1;
            chk("mul_busy", 32'(bus.Busy), 32'd1);
            chk("mul_acc_hold", 32'(bus.Acc), 32'hD0);
        end
        idle();
        #1;
        chk("mul_acc", 32'(bus.Acc), 32'hC3);
        chk("mul_done", 32'(bus.Done), 32'd1);
        chk("mul_busy_clr", 32'(bus.Busy), 32'd0);
        idle();

        set_acc(3, 0);
        tick(1'b1, 1'b1, 3'd4, 5);
        idle();
        tick(1'b0, 1'b0, 3'd0, 0);
        #1;
        chk("mrst_acc", 32'(bus.Acc), 32'h00);
        chk("mrst_busy", 32'(bus.Busy), 32'd0);
        idle();
        #1;
        chk("mrst_done", 32'(bus.Done), 32'd0);
        tick(1'b1, 1'b1, 3'd0, 1);
        #1;
        chk("mrst_add", 32'(bus.Acc), 32'h01);
        idle();
`else
        set_acc(5, 0);
        tick(1'b1, 1'b1, 3'd4, 2);
        #1;
        chk("nomul_acc", 32'(bus.Acc), 32'h50);
        chk("nomul_busy", 32'(bus.Busy), 32'd0);
        chk("nomul_done", 32'(bus.Done), 32'd1);
        idle();
`endif

        for (int i = 0; i < 400; i++) begin
            tick(($urandom_range(0, 63) != 0),
                 ($urandom_range(0, 9) < 7),
                 3'($urandom_range(0, 7)),
                 $urandom_range(0, MASK));
        end

        for (int i = 0; i < 2 * W + 4; i++) idle();
        chk("sb_drain", q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/param_alu_acc.md
# param_alu_acc

Parametrised successor to the lab 4 accumulator ALU. It holds a 2·WIDTH-bit accumulator register, `Acc`, and applies a 3-bit operation to an input operand `A` and the accumulator's upper half `B`. It adds a start/busy/done handshake, a registered carry flag, an accumulate-add mode and a multi-cycle shift-add multiplier. It sits between the switch/key inputs and the LED/HEX display path of the board top level.

## Interface
- WIDTH, 4, operand width; the accumulator is 2·WIDTH bits (WIDTH ≥ 2).
- Clock  in  1  rising-edge clock.
- Reset_b  in  1  synchronous, active-low reset.
- A  in  WIDTH  operand A.
- Op  in  3  operation select; sampled with Start.
- Start  in  1  one-cycle operation request.
- Acc  out  2·WIDTH  accumulator; B ≡ Acc[2W-1:W].
- Carry  out  1  registered carry/wrap flag.
- Busy  out  1  multi-cycle operation in progress.
- Done  out  1  one-cycle pulse marking the commit of any accepted operation.

## Operation
- **Reset** (Reset_b=0 at a rising edge): Acc=0, Carry=0, Busy=0, Done=0, multiplier state cleared. Reset has priority over every other event.
- **Acceptance rule:** Start=1 with Busy=0 accepts the operation. Start=1 while Busy=1 is ignored: no queueing, no error.
- **Opcodes**, with A and B zero-extended where needed:
  - 000 ADD: Acc ← {zeros, cout, A+B[W-1:0]}; Carry ← cout.
  - 001 ACCADD: Acc ← (Acc + zext(A)) mod 2^(2W); Carry ← 1 on wrap, else 0.
  - 010 NLOGIC: Acc ← {~(A|B), ~(A&B)}.
  - 011 ANYSET: Acc ← (|A or |B) ? {2'b11, zeros} : 0.
  - 100 MUL: Acc ← A·B, unsigned, full 2W-bit product, computed by the multi-cycle shift-add sequence.
  - 101 SWAP: Acc ← {B, ~A}.
  - 110 XLOGIC: Acc ← {A^B, A~^B}.
  - 111 HOLD: Acc unchanged.
- **Carry** is written only by 000 and 001; every other opcode leaves it unchanged.
- **State machine:** IDLE and MULT.
  - IDLE → MULT on an accepted MUL.
  - MULT → IDLE when the iteration counter reaches WIDTH-1.
  - All other opcodes stay in IDLE.
- **MUL datapath:** A and B are latched at acceptance. The internal product register is cleared. One multiplier bit is processed per cycle, LSB first. Acc keeps its old value until the commit edge; partial products are never visible on Acc.

## Timing
- **Single-cycle opcodes:** Start sampled at edge k → Acc/Carry updated at edge k; Done=1 during the cycle after edge k, for exactly one cycle.
- **MUL:** Start accepted at edge k → Busy=1 from edge k through edge k+WIDTH-1 → Acc written at edge k+WIDTH, Busy=0 after that edge, Done=1 for the following cycle.
- **Back-to-back:** Start may be asserted in the same cycle Done is high. It is accepted, so a new operation can be accepted every cycle for single-cycle opcodes.
- **Reset during MULT:** aborts the operation. No Done pulse, Acc=0 at that edge.
- **Op/A while Busy:** changes to Op or A while Busy=1 have no effect on the running multiply.

## Configuration
- PARAM_ALU_MUL_EN:
  - Defined: opcode 100 is the multi-cycle multiplier described above.
  - Undefined: no multiplier logic or counter is built. Opcode 100 behaves as HOLD (Acc, Carry unchanged, single-cycle Done pulse), and Busy is tied to 0.

## Test plan
- Reset: hold Reset_b=0 for two edges with Start=1, Op=001, A=5 → Acc=0x00, Carry=0, Busy=0, Done=0.
- ADD: Acc=0x70 (B=7), A=9, Op=000, Start pulse → Acc=0x10, Carry=1, Done one cycle later for one cycle.
- ACCADD wrap: Acc=0xFE, A=3, Op=001 → Acc=0x01, Carry=1. Then Op=101 → Acc=0x0C, Carry stays 1.
- MUL (macro defined): Acc=0xD0 (B=13), A=0xF, Op=100 → Busy high four cycles, Acc stays 0xD0 until commit, then Acc=0xC3, then Done pulse. A second Start during Busy is ignored.
- Reset mid-MUL: start a MUL, drop Reset_b on the second busy edge → Acc=0, Busy=0, no Done. A following ADD with A=1, B=0 gives Acc=0x01.
- Macro undefined: Op=100 with Acc=0x50, A=2 → Acc=0x50, Busy never asserted, Done pulses one cycle after Start.
